// File: rtl/ieee_adder_issue.sv
// Issue stage for an external combinational IEEE-754 single adder.
// Operand pairs queue in a small FIFO. The FIFO head drives the adder directly.
// The adder's sum is captured into a result register together with an 8-bit
// sequence tag. The block never looks at the operand bits themselves.

`ifndef WIDTH_NUMBER
`define WIDTH_NUMBER 32
`endif

module ieee_adder_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sub,
  input  logic [`WIDTH_NUMBER-1:0] in_a,
  input  logic [`WIDTH_NUMBER-1:0] in_b,
  output logic                     adder_sub,
  output logic [`WIDTH_NUMBER-1:0] adder_a,
  output logic [`WIDTH_NUMBER-1:0] adder_b,
  input  logic [`WIDTH_NUMBER-1:0] adder_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [`WIDTH_NUMBER-1:0] res_data,
  output logic [7:0]               res_tag,
  output logic [4:0]               occupancy
);

  localparam int W     = `WIDTH_NUMBER;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             mem_sub [DEPTH];
  logic [W-1:0]     mem_a   [DEPTH];
  logic [W-1:0]     mem_b   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [4:0]       occ_reg;
  logic [7:0]       tag_cnt_reg;
  logic             res_valid_reg;
  logic [W-1:0]     res_data_reg;
  logic [7:0]       res_tag_reg;

  logic             fifo_empty;
  logic             push;
  logic             pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  // An empty FIFO cannot pop the entry that is being pushed on the same edge.
  assign fifo_empty = (occ_reg == 5'd0);
  assign in_ready   = (occ_reg != 5'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (!res_valid_reg || res_ready);

  // The FIFO head drives the adder. The outputs are quiet zeros while the FIFO is empty.
  always_comb begin
    adder_sub = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    if (!fifo_empty) begin
      adder_sub = mem_sub[rd_ptr_reg];
      adder_a   = mem_a[rd_ptr_reg];
      adder_b   = mem_b[rd_ptr_reg];
    end
  end

  // Operand storage. The entries need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sub[wr_ptr_reg] <= in_sub;
      mem_a[wr_ptr_reg]   <= in_a;
      mem_b[wr_ptr_reg]   <= in_b;
    end
  end

  // Pointer and occupancy bookkeeping. The pointers wrap explicitly at DEPTH-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      occ_reg <= occ_reg + {4'd0, push} - {4'd0, pop};
    end
  end

  // Result register. It captures the adder output and a tag on each pop.
  // It holds while the consumer stalls and drains when the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_tag_reg   <= '0;
      tag_cnt_reg   <= '0;
    end else if (pop) begin
      res_valid_reg <= 1'b1;
      res_data_reg  <= adder_c;
      res_tag_reg   <= tag_cnt_reg;
      tag_cnt_reg   <= tag_cnt_reg + 8'd1;
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_tag   = res_tag_reg;
  assign occupancy = occ_reg;

endmodule
